// File: rtl/axis_frame_length_adjust_pkg.sv
// Shared types and constants for the AXI-stream frame length adjuster.
package axis_frame_length_adjust_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        TRANSFER = 2'd0,
        PAD      = 2'd1,
        TRUNCATE = 2'd2
    } state_e;

endpackage

// File: rtl/axis_output_register.sv
// Single-stage AXI-stream output register.
// Holds its word stable until the downstream handshake completes.
module axis_output_register #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic                  user_i,
    input  logic                  ready_i,
    output logic                  free_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  user_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic                  user_q;

    assign free_o  = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign user_o  = user_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (free_o) begin
            valid_q <= load_i;
            if (load_i) begin
                data_q <= data_i;
                last_q <= last_i;
                user_q <= user_i;
            end
        end
    end

endmodule

// File: rtl/axis_frame_length_adjust.sv
// Pads short frames and truncates long frames on an AXI stream,
// reporting one status record per input frame.
module axis_frame_length_adjust
    import axis_frame_length_adjust_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    LENGTH_MIN = 4,
    parameter int                    LENGTH_MAX = 8,
    parameter logic [DATA_WIDTH-1:0] PAD_BYTE   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic                  status_valid,
    output logic                  status_frame_pad,
    output logic                  status_frame_truncate,
    output logic [15:0]           status_frame_length
);

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(LENGTH_MIN);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(LENGTH_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic             user_q, user_d;
    logic             st_vld_q;
    logic             st_pad_q, st_pad_d;
    logic             st_trunc_q, st_trunc_d;
    logic [CNT_W-1:0] st_len_q, st_len_d;
    logic             st_pulse;

    logic [CNT_W-1:0] out_inc;
    logic [CNT_W-1:0] in_inc;
    logic             in_ready;
    logic             reg_free;
    logic             ld;
    logic [DATA_WIDTH-1:0] ld_data;
    logic             ld_last;
    logic             ld_user;

    assign out_inc = out_cnt_q + CNT_W'(1);
    assign in_inc  = (in_cnt_q == '1) ? in_cnt_q : in_cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q;
        in_cnt_d   = in_cnt_q;
        user_d     = user_q;
        in_ready   = 1'b0;
        ld         = 1'b0;
        ld_data    = input_axis_tdata;
        ld_last    = 1'b0;
        ld_user    = 1'b0;
        st_pulse   = 1'b0;
        st_pad_d   = 1'b0;
        st_trunc_d = 1'b0;
        st_len_d   = in_cnt_q;
        unique case (state_q)
            TRANSFER: begin
                in_ready = reg_free && !rst;
                if (input_axis_tvalid && in_ready) begin
                    ld        = 1'b1;
                    out_cnt_d = out_inc;
                    in_cnt_d  = in_inc;
                    if (input_axis_tlast) begin
                        if (out_inc >= MIN_C) begin
                            ld_last   = 1'b1;
                            ld_user   = input_axis_tuser;
                            st_pulse  = 1'b1;
                            st_len_d  = in_inc;
                            out_cnt_d = '0;
                            in_cnt_d  = '0;
                        end else begin
                            user_d  = input_axis_tuser;
                            state_d = PAD;
                        end
                    end else if (out_inc == MAX_C) begin
                        ld_last = 1'b1;
                        state_d = TRUNCATE;
                    end
                end
            end
            PAD: begin
                if (reg_free) begin
                    ld        = 1'b1;
                    ld_data   = PAD_BYTE;
                    out_cnt_d = out_inc;
                    if (out_inc == MIN_C) begin
                        ld_last   = 1'b1;
                        ld_user   = user_q;
                        st_pulse  = 1'b1;
                        st_pad_d  = 1'b1;
                        out_cnt_d = '0;
                        in_cnt_d  = '0;
                        state_d   = TRANSFER;
                    end
                end
            end
            TRUNCATE: begin
                // Drain surplus input even while the output is stalled.
                in_ready = !rst;
                if (input_axis_tvalid && in_ready) begin
                    in_cnt_d = in_inc;
                    if (input_axis_tlast) begin
                        st_pulse   = 1'b1;
                        st_trunc_d = 1'b1;
                        st_len_d   = in_inc;
                        out_cnt_d  = '0;
                        in_cnt_d   = '0;
                        state_d    = TRANSFER;
                    end
                end
            end
            default: state_d = TRANSFER;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= TRANSFER;
            out_cnt_q  <= '0;
            in_cnt_q   <= '0;
            user_q     <= 1'b0;
            st_vld_q   <= 1'b0;
            st_pad_q   <= 1'b0;
            st_trunc_q <= 1'b0;
            st_len_q   <= '0;
        end else begin
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
            in_cnt_q  <= in_cnt_d;
            user_q    <= user_d;
            st_vld_q  <= st_pulse;
            if (st_pulse) begin
                st_pad_q   <= st_pad_d;
                st_trunc_q <= st_trunc_d;
                st_len_q   <= st_len_d;
            end
        end
    end

    axis_output_register #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_oreg (
        .clk    (clk),
        .rst    (rst),
        .load_i (ld),
        .data_i (ld_data),
        .last_i (ld_last),
        .user_i (ld_user),
        .ready_i(output_axis_tready),
        .free_o (reg_free),
        .valid_o(output_axis_tvalid),
        .data_o (output_axis_tdata),
        .last_o (output_axis_tlast),
        .user_o (output_axis_tuser)
    );

    assign input_axis_tready     = in_ready;
    assign status_valid          = st_vld_q;
    assign status_frame_pad      = st_pad_q;
    assign status_frame_truncate = st_trunc_q;
    assign status_frame_length   = st_len_q;

endmodule

// File: tb/tb_axis_frame_length_adjust.sv
// Directed bench for axis_frame_length_adjust (MIN=4, MAX=8).
module tb_axis_frame_length_adjust;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  itdata = '0;
    logic        itvalid = 1'b0;
    logic        itready;
    logic        itlast = 1'b0;
    logic        ituser = 1'b0;
    logic [7:0]  otdata;
    logic        otvalid;
    logic        otready = 1'b1;
    logic        otlast;
    logic        otuser;
    logic        stv;
    logic        stpad;
    logic        sttrunc;
    logic [15:0] stlen;

    always #5 clk = ~clk;

    axis_frame_length_adjust #(
        .DATA_WIDTH(8),
        .LENGTH_MIN(4),
        .LENGTH_MAX(8),
        .PAD_BYTE  (8'h00)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .input_axis_tdata     (itdata),
        .input_axis_tvalid    (itvalid),
        .input_axis_tready    (itready),
        .input_axis_tlast     (itlast),
        .input_axis_tuser     (ituser),
        .output_axis_tdata    (otdata),
        .output_axis_tvalid   (otvalid),
        .output_axis_tready   (otready),
        .output_axis_tlast    (otlast),
        .output_axis_tuser    (otuser),
        .status_valid         (stv),
        .status_frame_pad     (stpad),
        .status_frame_truncate(sttrunc),
        .status_frame_length  (stlen)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    typedef struct packed {
        logic        pad;
        logic        trunc;
        logic [15:0] len;
    } stat_t;

    typedef struct {
        int         len;
        logic [7:0] base;
        logic       user;
        int         olen;
        logic       pad;
        logic       trunc;
        logic       ouser;
    } vec_t;

    beat_t outq[$];
    stat_t stq[$];
    int    tests = 0;
    int    fails = 0;
    int    stall_cnt = 0;
    int    stab_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d = '0;
    logic       prev_l = 1'b0;
    logic       prev_u = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (otvalid && otready) outq.push_back('{otdata, otlast, otuser});
            if (stv) stq.push_back('{stpad, sttrunc, stlen});
            if (prev_stall && (!otvalid || otdata != prev_d ||
                               otlast != prev_l || otuser != prev_u))
                stab_err <= stab_err + 1;
            prev_stall <= otvalid && !otready;
            prev_d     <= otdata;
            prev_l     <= otlast;
            prev_u     <= otuser;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_accept();
        logic hs;
        int   n = 0;
        forever begin
            @(negedge clk);
            hs = itvalid && itready;
            @(posedge clk);
            #1;
            if (hs) break;
            stall_cnt++;
            n++;
            if (n > 200) begin
                chk("accept_timeout", n, 0);
                break;
            end
        end
    endtask

    task automatic send_frame(input int len, input logic [7:0] base,
                              input logic user);
        for (int k = 1; k <= len; k++) begin
            itvalid = 1'b1;
            itdata  = base + 8'(k);
            itlast  = (k == len);
            ituser  = (k == len) ? user : 1'b0;
            wait_accept();
        end
        itvalid = 1'b0;
        itlast  = 1'b0;
        ituser  = 1'b0;
    endtask

    task automatic wait_status(input int n);
        int c = 0;
        while (stq.size() < n && c < 100) begin
            @(posedge clk);
            c++;
        end
        chk("status_seen", int'(stq.size() >= n), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string name, input int idx,
                            input logic [7:0] d, input logic l);
        if (idx < outq.size()) begin
            chk({name, "_data"}, outq[idx].d, d);
            chk({name, "_last"}, outq[idx].l, l);
        end else begin
            chk({name, "_missing"}, idx, -1);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2,  8'h00, 1'b0, 4, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{6,  8'h10, 1'b0, 6, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{10, 8'h20, 1'b0, 8, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8,  8'h30, 1'b1, 8, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{4,  8'h40, 1'b0, 4, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1,  8'h50, 1'b1, 4, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{9,  8'h60, 1'b1, 8, 1'b0, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", itready, 0);
        chk("rst_ovalid", otvalid, 0);
        chk("rst_stv", stv, 0);
        chk("rst_stlen", stlen, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_tready", itready, 1);
        @(posedge clk);
        #1;

        // Frame table
        foreach (vecs[i]) begin
            outq.delete();
            stq.delete();
            send_frame(vecs[i].len, vecs[i].base, vecs[i].user);
            wait_status(1);
            chk($sformatf("v%0d_olen", i), outq.size(), vecs[i].olen);
            for (int k = 0; k < vecs[i].olen; k++) begin
                logic [7:0] ed;
                ed = (k < vecs[i].len) ? vecs[i].base + 8'(k + 1) : 8'h00;
                chk_beat($sformatf("v%0d_w%0d", i, k), k, ed,
                         k == vecs[i].olen - 1);
            end
            if (outq.size() == vecs[i].olen)
                chk($sformatf("v%0d_ouser", i), outq[vecs[i].olen - 1].u,
                    vecs[i].ouser);
            chk($sformatf("v%0d_nstat", i), stq.size(), 1);
            if (stq.size() > 0) begin
                chk($sformatf("v%0d_pad", i), stq[0].pad, vecs[i].pad);
                chk($sformatf("v%0d_trunc", i), stq[0].trunc, vecs[i].trunc);
                chk($sformatf("v%0d_len", i), stq[0].len, vecs[i].len);
            end
        end

        // Input held off for exactly two pad cycles
        outq.delete();
        stq.delete();
        send_frame(2, 8'h00, 1'b0);
        @(negedge clk);
        chk("pad_rdy0", itready, 0);
        @(negedge clk);
        chk("pad_rdy1", itready, 0);
        @(negedge clk);
        chk("pad_rdy2", itready, 1);
        @(posedge clk);
        #1;
        wait_status(1);

        // Back-to-back exact-boundary frames
        outq.delete();
        stq.delete();
        stall_cnt = 0;
        send_frame(8, 8'h70, 1'b0);
        send_frame(4, 8'h80, 1'b0);
        chk("b2b_stalls", stall_cnt, 0);
        wait_status(2);
        chk("b2b_olen", outq.size(), 12);
        chk_beat("b2b_w7", 7, 8'h78, 1'b1);
        chk_beat("b2b_w8", 8, 8'h81, 1'b0);
        chk_beat("b2b_w11", 11, 8'h84, 1'b1);
        chk("b2b_nstat", stq.size(), 2);
        if (stq.size() == 2) begin
            chk("b2b_s0_trunc", stq[0].trunc, 0);
            chk("b2b_s0_len", stq[0].len, 8);
            chk("b2b_s1_pad", stq[1].pad, 0);
            chk("b2b_s1_len", stq[1].len, 4);
        end

        // Single word with toggling downstream ready
        outq.delete();
        stq.delete();
        stab_err = 0;
        otready = 1'b1;
        fork
            send_frame(1, 8'h54, 1'b1);
            begin
                repeat (16) begin
                    @(posedge clk);
                    #1;
                    otready = ~otready;
                end
                otready = 1'b1;
            end
        join
        wait_status(1);
        chk("stall_olen", outq.size(), 4);
        chk_beat("stall_w0", 0, 8'h55, 1'b0);
        chk_beat("stall_w1", 1, 8'h00, 1'b0);
        chk_beat("stall_w2", 2, 8'h00, 1'b0);
        chk_beat("stall_w3", 3, 8'h00, 1'b1);
        if (outq.size() == 4) chk("stall_user", outq[3].u, 1);
        chk("stall_stable", stab_err, 0);
        if (stq.size() > 0) begin
            chk("stall_pad", stq[0].pad, 1);
            chk("stall_len", stq[0].len, 1);
        end

        // Reset in the middle of a frame
        outq.delete();
        stq.delete();
        for (int k = 1; k <= 3; k++) begin
            itvalid = 1'b1;
            itdata  = 8'(k);
            itlast  = 1'b0;
            wait_accept();
        end
        itvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_tready", itready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ovalid", otvalid, 0);
        @(posedge clk);
        #1;
        outq.delete();
        send_frame(3, 8'h03, 1'b0);
        wait_status(1);
        chk("rst_olen", outq.size(), 4);
        chk_beat("rst_w0", 0, 8'h04, 1'b0);
        chk_beat("rst_w2", 2, 8'h06, 1'b0);
        chk_beat("rst_w3", 3, 8'h00, 1'b1);
        chk("rst_nstat", stq.size(), 1);
        if (stq.size() > 0) begin
            chk("rst_len", stq[0].len, 3);
            chk("rst_pad", stq[0].pad, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
